// File: rtl/spi_flash_reader.sv
// Single-lane mode-0 SPI master that wakes the flash (ABh) and serves CPU byte reads (03h),
// keeping chip select open so strictly sequential addresses stream without a new command.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV      = 2,
  parameter int unsigned WAKE_CYCLES  = 64,
  parameter int unsigned CSH_MIN      = 4,
  parameter int unsigned IDLE_TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [23:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        spi_csb,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    S_WAKE_CMD,
    S_WAKE_WAIT,
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_CS_HIGH
  } state_t;

  localparam logic [7:0]  CMD_RPD   = 8'hAB;
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] WAKE_LAST = 16'(WAKE_CYCLES - 1);
  localparam logic [15:0] CSH_LAST  = 16'(CSH_MIN - 1);
  localparam logic [15:0] TO_LAST   = 16'(IDLE_TIMEOUT - 1);

  state_t      state_q;
  logic        csb_q, sclk_q, mosi_q, ready_q, rsp_valid_q, pend_q;
  logic [7:0]  rsp_data_q, rx_q;
  logic [15:0] div_q, cnt_q;
  logic [4:0]  bit_q;
  logic [30:0] tx_q;
  logic [23:0] addr_q;

  logic        shifting_d, tick_d, rise_d, fall_d, accept_d, seq_hit_d;
  logic [7:0]  rx_byte_d;
  logic [23:0] next_addr_d;

  assign shifting_d  = (state_q == S_CMD) || (state_q == S_ADDR) || (state_q == S_DATA) ||
                       ((state_q == S_WAKE_CMD) && !csb_q);
  assign tick_d      = (div_q == DIV_LAST);
  assign rise_d      = tick_d && !sclk_q;
  assign fall_d      = tick_d && sclk_q;
  assign accept_d    = req_valid && ready_q;
  assign seq_hit_d   = (req_addr == addr_q);
  assign rx_byte_d   = {rx_q[6:0], spi_miso};
  assign next_addr_d = addr_q + 24'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAKE_CMD;
      csb_q       <= 1'b1;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      pend_q      <= 1'b0;
      div_q       <= 16'd0;
      cnt_q       <= 16'd0;
      bit_q       <= 5'd0;
    end else begin
      rsp_valid_q <= 1'b0;

      // SCLK divider: runs only while a frame is actively shifting
      if (shifting_d) begin
        if (tick_d) begin
          div_q  <= 16'd0;
          sclk_q <= ~sclk_q;
        end else begin
          div_q <= div_q + 16'd1;
        end
      end

      case (state_q)
        S_WAKE_CMD: begin
          if (csb_q) begin
            csb_q  <= 1'b0;
            sclk_q <= 1'b0;
            div_q  <= 16'd0;
            bit_q  <= 5'd0;
            mosi_q <= CMD_RPD[7];
            tx_q   <= {CMD_RPD[6:0], 24'h000000};
          end else if (fall_d) begin
            mosi_q <= tx_q[30];
            tx_q   <= {tx_q[29:0], 1'b0};
            if (bit_q == 5'd7) begin
              csb_q   <= 1'b1;
              cnt_q   <= 16'd0;
              state_q <= S_WAKE_WAIT;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
        end

        S_WAKE_WAIT: begin
          if (cnt_q == WAKE_LAST) begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_IDLE: begin
          if (accept_d) begin
            ready_q <= 1'b0;
            addr_q  <= req_addr;
            csb_q   <= 1'b0;
            sclk_q  <= 1'b0;
            div_q   <= 16'd0;
            bit_q   <= 5'd0;
            mosi_q  <= CMD_READ[7];
            tx_q    <= {CMD_READ[6:0], req_addr};
            state_q <= S_CMD;
          end
        end

        S_CMD: begin
          if (fall_d) begin
            mosi_q <= tx_q[30];
            tx_q   <= {tx_q[29:0], 1'b0};
            if (bit_q == 5'd7) begin
              bit_q   <= 5'd0;
              state_q <= S_ADDR;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
        end

        // the zero shifted in behind the address parks MOSI low for the data phase
        S_ADDR: begin
          if (fall_d) begin
            mosi_q <= tx_q[30];
            tx_q   <= {tx_q[29:0], 1'b0};
            if (bit_q == 5'd23) begin
              bit_q   <= 5'd0;
              state_q <= S_DATA;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
        end

        S_DATA: begin
          if (rise_d) begin
            rx_q <= rx_byte_d;
            if (bit_q == 5'd7) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= rx_byte_d;
            end
          end
          if (fall_d) begin
            if (bit_q == 5'd7) begin
              bit_q   <= 5'd0;
              addr_q  <= next_addr_d;
              cnt_q   <= 16'd0;
              ready_q <= 1'b1;
              state_q <= S_HOLD;
            end else begin
              bit_q <= bit_q + 5'd1;
            end
          end
        end

        // a request in the expiry cycle still wins over the timeout
        S_HOLD: begin
          if (accept_d) begin
            ready_q <= 1'b0;
            if (seq_hit_d) begin
              div_q   <= 16'd0;
              bit_q   <= 5'd0;
              state_q <= S_DATA;
            end else begin
              addr_q  <= req_addr;
              pend_q  <= 1'b1;
              csb_q   <= 1'b1;
              cnt_q   <= 16'd0;
              state_q <= S_CS_HIGH;
            end
          end else if (cnt_q == TO_LAST) begin
            ready_q <= 1'b0;
            pend_q  <= 1'b0;
            csb_q   <= 1'b1;
            cnt_q   <= 16'd0;
            state_q <= S_CS_HIGH;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        S_CS_HIGH: begin
          if (cnt_q == CSH_LAST) begin
            cnt_q <= 16'd0;
            if (pend_q) begin
              pend_q  <= 1'b0;
              csb_q   <= 1'b0;
              sclk_q  <= 1'b0;
              div_q   <= 16'd0;
              bit_q   <= 5'd0;
              mosi_q  <= CMD_READ[7];
              tx_q    <= {CMD_READ[6:0], addr_q};
              state_q <= S_CMD;
            end else begin
              ready_q <= 1'b1;
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end

        default: state_q <= S_WAKE_CMD;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign spi_csb   = csb_q;
  assign spi_clk   = sclk_q;
  assign spi_mosi  = mosi_q;

endmodule
